// File: rtl/fft_out_reorder_if.sv
// Sample-stream bundle for the FFT output reorder stage: the bit-reversed input
// stream from the last radix-4 unit and the natural-order, block-aligned output.
interface fft_out_reorder_if #(
  parameter int MAN_WIDTH = 16,
  parameter int EXP_WIDTH = 8
);
  logic                        block_sync_i;
  logic                        data_val_i;
  logic signed [MAN_WIDTH-1:0] data_real_i;
  logic signed [MAN_WIDTH-1:0] data_imag_i;
  logic signed [EXP_WIDTH-1:0] data_exp_i;
  logic [3:0]                  ldn_rg_i;

  logic                        block_sync_o;
  logic                        data_val_o;
  logic signed [MAN_WIDTH-1:0] data_real_o;
  logic signed [MAN_WIDTH-1:0] data_imag_o;
  logic signed [EXP_WIDTH-1:0] data_exp_o;
  logic                        sync_err_o;
  logic                        overflow_o;

  // Reorder stage side.
  modport slave (
    input  block_sync_i, data_val_i, data_real_i, data_imag_i, data_exp_i, ldn_rg_i,
    output block_sync_o, data_val_o, data_real_o, data_imag_o, data_exp_o,
           sync_err_o, overflow_o
  );

  // Producer / consumer side.
  modport master (
    output block_sync_i, data_val_i, data_real_i, data_imag_i, data_exp_i, ldn_rg_i,
    input  block_sync_o, data_val_o, data_real_o, data_imag_o, data_exp_o,
           sync_err_o, overflow_o
  );
endinterface

// File: rtl/fft_out_reorder.sv
// FFT output reorder: ping-pong buffer written in bit-reversed order, replayed
// in natural bin order with every mantissa aligned to the block max exponent.

// One alignment lane: arithmetic right shift, clamped to MAN_WIDTH-1.
module fft_out_reorder_lane #(
  parameter int MAN_WIDTH = 16,
  parameter int EXP_WIDTH = 8
) (
  input  logic [MAN_WIDTH-1:0] man,
  input  logic [EXP_WIDTH:0]   sh,
  output logic [MAN_WIDTH-1:0] res
);
  localparam int SH_MAX = MAN_WIDTH - 1;
  logic [EXP_WIDTH:0] amt;

  // Clamp the shift so large gaps saturate at 0 or -1 instead of wrapping.
  always_comb begin
    amt = sh;
    if (int'(sh) > SH_MAX) amt = (EXP_WIDTH+1)'(SH_MAX);
    res = $signed(man) >>> amt;
  end
endmodule

module fft_out_reorder #(
  parameter int LDN_MAX   = 11,
  parameter int MAN_WIDTH = 16,
  parameter int EXP_WIDTH = 8
) (
  input logic           clk_sys,
  input logic           rst_sys_n,
  fft_out_reorder_if.slave io
);
  localparam int DEPTH     = 1 << LDN_MAX;
  localparam int WORD_W    = 2*MAN_WIDTH + EXP_WIDTH;
  localparam int NUM_LANES = 2;
  localparam int STAGES    = 2;

  typedef struct packed {
    logic [MAN_WIDTH-1:0] re;
    logic [MAN_WIDTH-1:0] im;
    logic [EXP_WIDTH-1:0] ex;
  } word_t;

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LDN_MAX-1:0] last_idx(input logic [3:0] ldn);
    logic [LDN_MAX:0] n;
    n = (LDN_MAX+1)'(1) << ldn;
    n = n - 1'b1;
    return n[LDN_MAX-1:0];
  endfunction

  function automatic logic [LDN_MAX-1:0] bitrev(input logic [LDN_MAX-1:0] v,
                                                input logic [3:0] ldn);
    logic [LDN_MAX-1:0] r;
    for (int i = 0; i < LDN_MAX; i++) r[i] = v[LDN_MAX-1-i];
    return r >> (4'(LDN_MAX) - ldn);
  endfunction

  // write side state
  logic                        started, wbank;
  logic [LDN_MAX-1:0]          wcnt;
  logic [3:0]                  wldn;
  logic signed [EXP_WIDTH-1:0] emax_w;
  logic [1:0]                  full, full_nxt;
  logic [1:0][3:0]             blk_ldn;
  logic [1:0][EXP_WIDTH-1:0]   blk_emax;
  logic                        sync_err_q, overflow_q;

  logic                        wr_en, w_sync, w_last, drop;
  logic [3:0]                  cur_ldn;
  logic [LDN_MAX-1:0]          cur_cnt, wr_addr;
  logic signed [EXP_WIDTH-1:0] cur_emax;
  word_t                       wdata;

  // read side state
  state_t             state, state_nxt;
  logic               rbank, rbank_nxt;
  logic [LDN_MAX-1:0] raddr, raddr_nxt;
  logic               rd_en, rd_done;

  logic [WORD_W-1:0] mem [0:2*DEPTH-1];
  word_t             rd_word;

  // pipeline: [0] = RAM output, [1] = aligned output
  logic [STAGES-1:0]           vld_pipe, sy_pipe;
  logic signed [EXP_WIDTH-1:0] emax_s1;
  logic [EXP_WIDTH:0]          sh;
  logic [NUM_LANES-1:0][MAN_WIDTH-1:0] lane_man, lane_res;
  logic [MAN_WIDTH-1:0]        out_re, out_im;
  logic [EXP_WIDTH-1:0]        out_ex;

  assign wdata   = {io.data_real_i, io.data_imag_i, io.data_exp_i};
  assign rd_en   = (state == READ);
  assign rd_done = rd_en && (raddr == last_idx(blk_ldn[rbank]));

  // Write address, block exponent tracking and full-flag bookkeeping.
  always_comb begin
    wr_en    = io.data_val_i && (started || io.block_sync_i);
    w_sync   = wr_en && io.block_sync_i;
    cur_ldn  = w_sync ? io.ldn_rg_i : wldn;
    cur_cnt  = w_sync ? '0 : wcnt;
    cur_emax = emax_w;
    if (cur_cnt == '0 || io.data_exp_i > emax_w) cur_emax = io.data_exp_i;
    wr_addr  = bitrev(cur_cnt, cur_ldn);
    w_last   = wr_en && (cur_cnt == last_idx(cur_ldn));
    // The other bank only counts as busy if it is not being released this cycle.
    drop     = w_last && full[~wbank] && !(rd_done && (rbank != wbank));
    full_nxt = full;
    if (rd_done) full_nxt[rbank] = 1'b0;
    if (w_last && !drop) full_nxt[wbank] = 1'b1;
  end

  // Write counter, bank selection and per-bank block descriptors.
  // A dropped block leaves the writer on its own (still free) bank so the bank
  // being read is never overwritten.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      started    <= 1'b0;
      wbank      <= 1'b0;
      wcnt       <= '0;
      wldn       <= '0;
      emax_w     <= '0;
      full       <= '0;
      blk_ldn    <= '0;
      blk_emax   <= '0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      full       <= full_nxt;
      sync_err_q <= w_sync && (wcnt != '0);
      overflow_q <= drop;
      if (w_sync) started <= 1'b1;
      if (wr_en) begin
        wldn   <= cur_ldn;
        emax_w <= cur_emax;
        if (w_last) begin
          wcnt <= '0;
          if (!drop) begin
            blk_ldn[wbank]  <= cur_ldn;
            blk_emax[wbank] <= cur_emax;
            wbank           <= ~wbank;
          end
        end else begin
          wcnt <= cur_cnt + 1'b1;
        end
      end
    end
  end

  // Dual-bank sample RAM, one write and one registered read per cycle.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[{wbank, wr_addr}] <= wdata;
    rd_word <= mem[{rbank, raddr}];
  end

  // Read FSM state register.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state <= IDLE;
      rbank <= 1'b0;
      raddr <= '0;
    end else begin
      state <= state_nxt;
      rbank <= rbank_nxt;
      raddr <= raddr_nxt;
    end
  end

  // Read FSM next state; sees same-cycle completions so blocks chain gap-free.
  always_comb begin
    state_nxt = state;
    rbank_nxt = rbank;
    raddr_nxt = raddr;
    case (state)
      IDLE: begin
        raddr_nxt = '0;
        if (full_nxt[rbank]) state_nxt = READ;
      end
      READ: begin
        if (rd_done) begin
          raddr_nxt = '0;
          rbank_nxt = ~rbank;
          state_nxt = full_nxt[~rbank] ? READ : IDLE;
        end else begin
          raddr_nxt = raddr + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sh          = {emax_s1[EXP_WIDTH-1], emax_s1} - {rd_word.ex[EXP_WIDTH-1], rd_word.ex};
  assign lane_man[0] = rd_word.re;
  assign lane_man[1] = rd_word.im;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fft_out_reorder_lane #(.MAN_WIDTH(MAN_WIDTH), .EXP_WIDTH(EXP_WIDTH)) u_lane (
      .man (lane_man[g]),
      .sh  (sh),
      .res (lane_res[g])
    );
  end

  // Valid/sync shift register and the alignment output register.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      vld_pipe <= '0;
      sy_pipe  <= '0;
      emax_s1  <= '0;
      out_re   <= '0;
      out_im   <= '0;
      out_ex   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd_en};
      sy_pipe  <= {sy_pipe[0], rd_en && (raddr == '0)};
      emax_s1  <= blk_emax[rbank];
      if (vld_pipe[0]) begin
        out_re <= lane_res[0];
        out_im <= lane_res[1];
        out_ex <= emax_s1;
      end
    end
  end

  assign io.data_val_o   = vld_pipe[1];
  assign io.block_sync_o = sy_pipe[1];
  assign io.data_real_o  = out_re;
  assign io.data_imag_o  = out_im;
  assign io.data_exp_o   = out_ex;
  assign io.sync_err_o   = sync_err_q;
  assign io.overflow_o   = overflow_q;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: table-driven single blocks plus
// hand-written back-to-back, overflow, resync and reset sequences.
module tb_fft_out_reorder;
  localparam int MW = 16;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_out_reorder_if #(.MAN_WIDTH(MW), .EXP_WIDTH(EW)) io();

  fft_out_reorder #(.LDN_MAX(11), .MAN_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk_sys   (clk),
    .rst_sys_n (rst_n),
    .io        (io)
  );

  typedef struct {
    int blk; int ldn;
    int re;  int im;  int ex;    // input at stream position j
    int ere; int eim; int eex;   // expected output at bin j
  } vec_t;

  vec_t vt[$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int q_re[$], q_im[$], q_ex[$], q_sy[$], q_cy[$];
  int ovf_cnt = 0, err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (io.data_val_o) begin
      q_re.push_back(int'(io.data_real_o));
      q_im.push_back(int'(io.data_imag_o));
      q_ex.push_back(int'(io.data_exp_o));
      q_sy.push_back(int'(io.block_sync_o));
      q_cy.push_back(cyc);
    end
    if (io.overflow_o) ovf_cnt++;
    if (io.sync_err_o) err_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if (v[i]) r |= 1 << (bits - 1 - i);
    return r;
  endfunction

  task automatic clr_q();
    q_re.delete(); q_im.delete(); q_ex.delete(); q_sy.delete(); q_cy.delete();
    ovf_cnt = 0; err_cnt = 0;
  endtask

  task automatic put(input bit sy, input int ldn, input int re, input int im, input int ex);
    @(posedge clk); #1;
    io.data_val_i   = 1'b1;
    io.block_sync_i = sy;
    io.ldn_rg_i     = 4'(ldn);
    io.data_real_i  = MW'(re);
    io.data_imag_i  = MW'(im);
    io.data_exp_i   = EW'(ex);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      io.data_val_i   = 1'b0;
      io.block_sync_i = 1'b0;
    end
  endtask

  task automatic add(input int b, input int ldn, input int re, input int im, input int ex,
                     input int ere, input int eim, input int eex);
    vec_t v;
    v.blk = b; v.ldn = ldn; v.re = re; v.im = im; v.ex = ex;
    v.ere = ere; v.eim = eim; v.eex = eex;
    vt.push_back(v);
  endtask

  // Send one table block, then compare count, latency, framing and every bin.
  task automatic run_blk(input int b);
    vec_t blk[$];
    int c, n, bad;
    foreach (vt[i]) if (vt[i].blk == b) blk.push_back(vt[i]);
    n = blk.size();
    clr_q();
    foreach (blk[j]) put(j == 0, blk[j].ldn, blk[j].re, blk[j].im, blk[j].ex);
    c = cyc;
    idle(1);
    repeat (n + 8) @(posedge clk);
    check($sformatf("blk%0d count", b), q_re.size(), n);
    if (q_re.size() == n) begin
      check($sformatf("blk%0d first valid cycle", b), q_cy[0], c + 3);
      bad = 0;
      for (int k = 0; k < n; k++) begin
        if (q_sy[k] != (k == 0 ? 1 : 0)) bad++;
        if (q_cy[k] != q_cy[0] + k) bad++;
        check($sformatf("blk%0d bin%0d real", b, k), q_re[k], blk[k].ere);
        check($sformatf("blk%0d bin%0d imag", b, k), q_im[k], blk[k].eim);
        check($sformatf("blk%0d bin%0d exp", b, k), q_ex[k], blk[k].eex);
      end
      check($sformatf("blk%0d sync/contiguity errors", b), bad, 0);
    end
  endtask

  initial begin
    int c, n0, bad;
    io.data_val_i = 0; io.block_sync_i = 0; io.ldn_rg_i = 0;
    io.data_real_i = 0; io.data_imag_i = 0; io.data_exp_i = 0;

    // Block 0: N=16 natural order.  Block 1: N=8.
    for (int j = 0; j < 16; j++) add(0, 4, brev(j, 4), -brev(j, 4), 0, j, -j, 0);
    for (int j = 0; j < 8; j++)  add(1, 3, 8*brev(j, 3), -brev(j, 3), 0, 8*j, -j, 0);
    // Block 2: exponent alignment, emax = 2.
    add(2, 2,  100, 0, 0,   25, 0, 2);
    add(2, 2, -100, 0, 2,   32, 0, 2);
    add(2, 2,   64, 0, 1, -100, 0, 2);
    add(2, 2,    1, 0, 2,    1, 0, 2);
    // Block 3: shift of 40 clamps to 15 (emax = 20, low exps = -20).
    add(3, 2, -5,  5, -20, -1,  0, 20);
    add(3, 2,  7, -3,  20,  0, -1, 20);
    add(3, 2,  5, -3, -20,  7, -3, 20);
    add(3, 2,  0,  0,  20,  0,  0, 20);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset data_val_o", int'(io.data_val_o), 0);
    check("reset block_sync_o", int'(io.block_sync_o), 0);
    check("reset data_real_o", int'(io.data_real_o), 0);
    check("reset data_exp_o", int'(io.data_exp_o), 0);
    check("reset pulses", int'(io.sync_err_o) + int'(io.overflow_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Samples before the first block sync are ignored.
    clr_q();
    for (int j = 0; j < 4; j++) put(0, 2, 50 + j, 0, 0);
    idle(1);
    repeat (12) @(posedge clk);
    check("pre-sync outputs", q_re.size(), 0);
    check("pre-sync sync_err", err_cnt, 0);

    for (int b = 0; b < 4; b++) begin
      run_blk(b);
      idle(2);
    end

    // Three continuous N=64 blocks -> 192 gap-free outputs, no overflow.
    clr_q();
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < 64; j++) put(j == 0, 6, brev(j, 6) + 64*b, b, 0);
    idle(1);
    repeat (80) @(posedge clk);
    check("b2b count", q_re.size(), 192);
    check("b2b overflow", ovf_cnt, 0);
    if (q_re.size() == 192) begin
      bad = 0;
      for (int i = 0; i < 192; i++) begin
        if (q_re[i] != i) bad++;
        if (q_im[i] != i / 64) bad++;
        if (q_cy[i] != q_cy[0] + i) bad++;
        if (q_sy[i] != ((i % 64) == 0 ? 1 : 0)) bad++;
      end
      check("b2b data/sync/contiguity errors", bad, 0);
    end

    // N=4 block right behind N=64: reader still busy -> dropped.
    clr_q();
    for (int j = 0; j < 64; j++) put(j == 0, 6, brev(j, 6) + 300, 0, 0);
    for (int j = 0; j < 4; j++)  put(j == 0, 2, 1000 + j, 0, 0);
    idle(1);
    repeat (80) @(posedge clk);
    check("ovf pulses", ovf_cnt, 1);
    check("ovf count", q_re.size(), 64);
    bad = 0;
    foreach (q_re[i]) if (q_re[i] != 300 + i) bad++;
    check("ovf data errors (dropped block must not appear)", bad, 0);
    idle(2);

    // Resync at wcnt=5 of N=16: only the restarted block is output.
    clr_q();
    for (int j = 0; j < 5; j++)  put(j == 0, 4, 900 + j, 0, 0);
    for (int j = 0; j < 16; j++) put(j == 0, 4, brev(j, 4) + 200, 0, 0);
    idle(1);
    repeat (30) @(posedge clk);
    check("resync sync_err pulses", err_cnt, 1);
    check("resync count", q_re.size(), 16);
    bad = 0;
    foreach (q_re[i]) if (q_re[i] != 200 + i || q_sy[i] != (i == 0 ? 1 : 0)) bad++;
    check("resync data errors", bad, 0);

    // Reset mid-read.
    clr_q();
    for (int j = 0; j < 16; j++) put(j == 0, 4, brev(j, 4) + 400, 0, 0);
    idle(1);
    repeat (6) @(posedge clk);
    check("reset mid-read: reading", (q_re.size() > 0 && q_re.size() < 16) ? 1 : 0, 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst mid data_val_o", int'(io.data_val_o), 0);
    check("rst mid block_sync_o", int'(io.block_sync_o), 0);
    check("rst mid data_real_o", int'(io.data_real_o), 0);
    check("rst mid data_exp_o", int'(io.data_exp_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = q_re.size();
    repeat (40) @(posedge clk);
    check("no output after reset", q_re.size(), n0);

    // Fresh block after reset works.
    for (int j = 0; j < 4; j++) put(j == 0, 2, 7*j, 0, 0);
    c = cyc;
    idle(1);
    repeat (12) @(posedge clk);
    check("post-reset count", q_re.size(), n0 + 4);
    if (q_re.size() == n0 + 4) begin
      check("post-reset first cycle", q_cy[n0], c + 3);
      check("post-reset bin1", q_re[n0 + 1], 14);
      check("post-reset bin2", q_re[n0 + 2], 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output stage of the pipeline FFT. It receives the block-floating-point sample stream from the last radix-4 unit, which arrives in bit-reversed order with a per-sample exponent. It stores each block in a ping-pong buffer and replays it in natural bin order, with every sample aligned to one common block exponent. It sits between the final `radix4_unit2` output and the downstream consumer (demapper/DFT post-processing).

## Interface
- `LDN_MAX`, default 11: log2 of the largest FFT size (2048). Each buffer bank holds 2^LDN_MAX entries.
- Mantissa and exponent widths come from `MAN_WIDTH` / `EXP_WIDTH` in `fixed_point.v`.
- Clocking and reset: one clock; reset is asynchronous and active-low.

Ports:
- `clk_sys` in 1: system clock, rising edge.
- `rst_sys_n` in 1: asynchronous active-low reset.
- `block_sync_i` in 1: marks the first sample of an input block; only valid with `data_val_i`.
- `data_val_i` in 1: input sample valid.
- `data_real_i`, `data_imag_i` in `MAN_WIDTH` signed: input mantissas.
- `data_exp_i` in `EXP_WIDTH` signed: input exponent; sample value = mantissa·2^exp.
- `ldn_rg_i` in 4: log2 FFT size; legal range 1..LDN_MAX; sampled when `block_sync_i` is accepted.
- `block_sync_o` out 1: high with the first output sample (bin 0) of a block.
- `data_val_o` out 1: output sample valid.
- `data_real_o`, `data_imag_o` out `MAN_WIDTH` signed: aligned mantissas.
- `data_exp_o` out `EXP_WIDTH` signed: block exponent, constant for the whole output block.
- `sync_err_o` out 1: one-cycle pulse when `block_sync_i` arrives mid-block.
- `overflow_o` out 1: one-cycle pulse when a completed block is dropped.

## Operation
- **Write side**
  - A counter `wcnt` runs from 0 to N-1, with N = 2^ldn latched at block sync.
  - Each sample is written to address `bitrev_ldn(wcnt)` of the write bank. Stored word = {real, imag, exp}.
  - Samples with `data_val_i` high before the first `block_sync_i` are ignored.
  - During the write the block records the running maximum exponent `emax`.
  - Completion at wcnt = N-1:
    - The bank is marked full, with its N and `emax`.
    - The write bank toggles and `wcnt` clears.
  - If the new write bank is still full (not yet read): the completed block is discarded, its bank is not marked full, and `overflow_o` pulses.
- **`block_sync_i` while wcnt ≠ 0**
  - Pulse `sync_err_o`.
  - Restart the write at address 0 of the same bank, with a new N and with `emax` reset to the current sample's exponent.
- **Read FSM**
  - IDLE: go to READ when the read bank is full.
  - READ: issue addresses 0..N-1, one per cycle.
  - After the last address, clear that bank's full flag, toggle the read bank, and return to IDLE. If the other bank is already full, go straight to READ with no idle cycle.
- **Alignment (one stage after the RAM)**
  - sh = emax − exp_stored.
  - Each mantissa is arithmetic-shifted right by min(sh, `MAN_WIDTH`−1), truncating toward −∞.
  - `data_exp_o` = emax.
- **Simultaneous events**
  - A write to bank X and a read of bank Y in the same cycle are always legal.
  - Write completion and read completion in the same cycle: both flag updates take effect; set and clear target different banks.

## Timing
- RAM read latency is 1 cycle; the alignment register adds 1 cycle.
- Let cycle t be the last-sample write. Then:
  - t+1: READ state, address 0.
  - t+3: `data_val_o` and `block_sync_o` high.
  - `data_val_o` then stays high for exactly N consecutive cycles.
- A continuous input at one sample per cycle with fixed N gives back-to-back output blocks with no gaps and no overflow.
- Reset values:
  - All outputs are 0.
  - FSM in IDLE, both banks empty, `wcnt` = 0, write and read bank both 0, waiting for block sync.
- Reset asserted mid-block or mid-read aborts everything immediately. Buffered data is never output after reset.

## Test plan
- **N=16, natural order.** ldn=4; input real = bitrev4(n), imag = −bitrev4(n), exp = 0, n = 0..15 → out real = 0..15, imag = 0..−15, exp = 0, `block_sync_o` at bin 0, first valid at t+3.
- **N=8, odd ldn.** ldn=3; input real = 8·bitrev3(n) → out real = 0, 8, …, 56 in natural order, exactly 8 valid cycles.
- **Exponent alignment.** ldn=2; samples real = 100, −100, 64, 1, in that input order, with exps 0, 2, 1, 2 → `data_exp_o` = 2. Outputs in bin order (bins = bitrev2 of input positions):
  - bin 0: 25
  - bin 1: 32
  - bin 2: −100
  - bin 3: 1
- **Large shift clamps.** sh = 40 with `MAN_WIDTH` = 16, input −5 → −1; input +5 → 0.
- **Back-to-back blocks.** Three N=64 blocks, continuous → 192 continuous valid outputs, three `block_sync_o` pulses 64 cycles apart, no `overflow_o`. Then a stalled reader scenario forced by an N=4 block following N=64 → `overflow_o` pulse, and the dropped block never appears.
- **Resync and reset.** `block_sync_i` at wcnt=5 of N=16 → `sync_err_o` pulse, and only the restarted 16-sample block is output. `rst_sys_n` low mid-read → outputs 0 next cycle, and nothing more is output until a new full block.
